// File: rtl/bilat_norm_acc.sv
// bilat_norm_acc: bilateral-filter normalizer, accumulates sum(w*p) and sum(w) per window then divides serially.
// Define BILAT_ROUND_EN for round-half-up division; otherwise the quotient is truncated.
module bilat_norm_acc #(
  parameter int TAPS = 121,
  parameter int WW   = 14,
  parameter int PW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WW-1:0] in_w,
  input  logic [PW-1:0] in_p,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pix,
  output logic          out_err
);
  localparam int CW = $clog2(TAPS + 1);
  localparam int NW = WW + PW + $clog2(TAPS);
  localparam int DW = WW + $clog2(TAPS);
  localparam int IW = $clog2(PW + 1);
  typedef enum logic [1:0] {ACC, LOAD, DIV, OUT} state_t;
  state_t          state_q;
  logic [NW-1:0]   num_q, rem_q, rem_d;
  logic [DW-1:0]   den_q;
  logic [DW+PW-2:0] dsh_q;
  logic [PW-1:0]   quo_q, ctr_q, out_pix_q;
  logic [CW-1:0]   tap_q;
  logic [IW-1:0]   it_q;
  logic            err_q, ovf_q, in_ready_q, out_valid_q, out_err_q;
  logic            take, last_tap, ge;
  assign take      = in_valid & in_ready_q;
  assign last_tap  = tap_q == CW'(TAPS - 1);
  assign ge        = rem_q >= NW'(dsh_q);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_err   = out_err_q;
`ifdef BILAT_ROUND_EN
  assign rem_d = num_q + NW'(den_q >> 1);
`else
  assign rem_d = num_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      num_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      dsh_q       <= '0;
      quo_q       <= '0;
      ctr_q       <= '0;
      out_pix_q   <= '0;
      tap_q       <= '0;
      it_q        <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: if (take) begin
          num_q <= num_q + NW'(in_w) * NW'(in_p);
          den_q <= den_q + DW'(in_w);
          tap_q <= tap_q + 1'b1;
          if (tap_q == CW'(TAPS / 2)) ctr_q <= in_p;
          if (in_last != last_tap) err_q <= 1'b1;
          if (last_tap) begin
            in_ready_q <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          rem_q   <= rem_d;
          dsh_q   <= {den_q, {(PW-1){1'b0}}};
          ovf_q   <= rem_d >= {den_q, {PW{1'b0}}};
          quo_q   <= '0;
          it_q    <= '0;
          state_q <= DIV;
        end
        // PW restoring steps with a shrinking divisor, then one edge to register the result
        DIV: if (it_q == IW'(PW)) begin
          out_pix_q   <= den_q == '0 ? ctr_q : ovf_q ? '1 : quo_q;
          out_err_q   <= err_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end else begin
          if (ge) rem_q <= rem_q - NW'(dsh_q);
          quo_q <= {quo_q[PW-2:0], ge};
          dsh_q <= dsh_q >> 1;
          it_q  <= it_q + 1'b1;
        end
        OUT: if (out_ready) begin
          num_q       <= '0;
          den_q       <= '0;
          tap_q       <= '0;
          err_q       <= 1'b0;
          out_valid_q <= 1'b0;
          out_err_q   <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_bilat_norm_acc.sv
// tb_bilat_norm_acc: directed and randomized windows checked against an arithmetic weighted-mean model.
module tb_bilat_norm_acc;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [13:0] in_w = '0;
  logic [7:0]  in_p = '0;
  logic        in_ready, out_valid, out_err;
  logic [7:0]  out_pix;
  int checks = 0, errors = 0, cyc = 0, t_last = 0;
  int wa[121], pa[121];
  bit la[121];

  bilat_norm_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
    .in_p(in_p), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int w, input int p);
    for (int i = 0; i < 121; i++) begin
      wa[i] = w;
      pa[i] = p;
      la[i] = (i == 120);
    end
  endtask

  task automatic model(output logic [31:0] pix, output logic [31:0] err);
    longint num = 0, den = 0, q;
    err = 0;
    for (int i = 0; i < 121; i++) begin
      num += longint'(wa[i]) * longint'(pa[i]);
      den += wa[i];
      if (la[i] != (i == 120)) err = 1;
    end
    if (den == 0) pix = pa[60];
    else begin
`ifdef BILAT_ROUND_EN
      num += den / 2;
`endif
      q = num / den;
      pix = (q > 255) ? 32'd255 : 32'(q);
    end
  endtask

  task automatic send(input int n, input bit gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_w = 14'(wa[i]);
      in_p = 8'(pa[i]);
      in_last = la[i];
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) check("send_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    t_last = cyc;
  endtask

  task automatic get_out(input string tag, input int hold);
    logic [31:0] ep, ee;
    int g = 0;
    model(ep, ee);
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_lat"}, cyc - t_last, 10);
    check({tag, "_pix"}, out_pix, ep);
    check({tag, "_err"}, out_err, ee);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_pix"}, out_pix, ep);
      check({tag, "_hold_rdy"}, in_ready, 0);
      check({tag, "_hold_vld"}, out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(64, 100);
    send(121, 0);
    in_valid = 1'b1;
    in_w = 14'd5000;
    in_p = 8'd9;
    get_out("uniform", 5);

    fill(0, 200);
    pa[60] = 77;
    send(121, 0);
    get_out("zero_w", 0);

    fill(0, 0);
    wa[0] = 1;
    wa[1] = 1;
    pa[1] = 1;
    send(121, 0);
    get_out("round", 0);

    fill(16383, 255);
    send(121, 1);
    get_out("max", 1);

    fill(64, 100);
    la[50] = 1'b1;
    send(121, 0);
    get_out("framing", 0);

    fill(64, 100);
    send(41, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(64, 30);
    send(121, 0);
    get_out("midrst", 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 121; i++) begin
        wa[i] = (r % 3 == 0) ? int'($urandom_range(0, 16383)) :
                (r % 3 == 1) ? int'($urandom_range(0, 3)) :
                ($urandom_range(0, 9) == 0 ? int'($urandom_range(0, 500)) : 0);
        pa[i] = int'($urandom_range(0, 255));
        la[i] = (i == 120);
      end
      if (r == 5) la[$urandom_range(0, 119)] = 1'b1;
      send(121, 1);
      get_out($sformatf("rand%0d", r), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
